// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared op codes, states and default latencies for the MDU sequencer
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

endpackage

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - E-stage issue and hazard-unit signals of the MDU sequencer
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        md_use_d;
  logic        busy;
  logic        stall_req;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op_e, rs_e, rt_e, md_use_d,
    input  busy, stall_req, rd_data, hi, lo
  );

  modport slave (
    input  start, op_e, rs_e, rt_e, md_use_d,
    output busy, stall_req, rd_data, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath producing {hi,lo} and a write enable
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        we
);

  always_comb begin
    result = '0;
    we     = 1'b0;
    case (op)
      OP_MULT: begin
        result = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
        we     = 1'b1;
      end
      OP_MULTU: begin
        result = {32'd0, rs} * {32'd0, rt};
        we     = 1'b1;
      end
      OP_DIV: begin
        if (rt != 32'd0) begin
          we = 1'b1;
          // the one signed quotient that overflows 32 bits is pinned explicitly
          if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)
            result = {32'd0, 32'h8000_0000};
          else
            result = {$signed(rs) % $signed(rt), $signed(rs) / $signed(rt)};
        end
      end
      OP_DIVU: begin
        if (rt != 32'd0) begin
          we     = 1'b1;
          result = {rs % rt, rs / rt};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU sequencer: latency FSM, result staging, HI/LO and stall request
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input logic        clk,
  input logic        reset,
  mdu_ctrl_if.slave  bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   stage_q, stage_d;
  logic          stage_we_q, stage_we_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   arith_result;
  logic          arith_we;
  logic          busy;

  mdu_arith u_arith (
    .op     (bus.op_e),
    .rs     (bus.rs_e),
    .rt     (bus.rt_e),
    .result (arith_result),
    .we     (arith_we)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stage_q    <= '0;
      stage_we_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      stage_we_q <= stage_we_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    stage_we_d = stage_we_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      ST_IDLE: begin
        // operands are captured once here; later changes on rs_e/rt_e are irrelevant
        if (bus.start) begin
          case (bus.op_e)
            OP_MULT, OP_MULTU: begin
              state_d    = ST_MUL;
              cnt_d      = CW'(MUL_CYCLES - 1);
              stage_d    = arith_result;
              stage_we_d = arith_we;
            end
            OP_DIV, OP_DIVU: begin
              state_d    = ST_DIV;
              cnt_d      = CW'(DIV_CYCLES - 1);
              stage_d    = arith_result;
              stage_we_d = arith_we;
            end
            OP_MTHI: hi_d = bus.rs_e;
            OP_MTLO: lo_d = bus.rs_e;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (stage_we_q) begin
            hi_d = stage_q[63:32];
            lo_d = stage_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy          = (state_q != ST_IDLE);
  assign bus.busy      = busy;
  assign bus.stall_req = bus.md_use_d & (bus.start | busy);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  always_comb begin
    case (bus.op_e)
      OP_MFHI: bus.rd_data = hi_q;
      OP_MFLO: bus.rd_data = lo_q;
      default: bus.rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with a cycle-timestamp reference model
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_ctrl_if mif ();

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: {write_enable, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'd0, a};
    longint ub = {32'd0, b};
    case (op)
      OP_MULT:  return {1'b1, sa * sb};
      OP_MULTU: return {1'b1, ua * ub};
      OP_DIV:   return (b == 0) ? 65'd0 : {1'b1, 32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  return (b == 0) ? 65'd0 : {1'b1, 32'(ua % ub), 32'(ua / ub)};
      default:  return 65'd0;
    endcase
  endfunction

  // model: a start in cycle t keeps the unit busy in cycles t+1..t+N, result visible from t+N+1
  longint      cyc = 0;
  longint      busy_until = -1;
  longint      pend_at = 0;
  bit          pend = 0;
  bit          pend_we = 0;
  logic [63:0] pend_val = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  bit          model_ok = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_hi = '0; m_lo = '0; busy_until = -1; pend = 0; model_ok = 1;
    end else if (model_ok) begin
      if (pend && cyc == pend_at) begin
        if (pend_we) {m_hi, m_lo} = pend_val;
        pend = 0;
      end
      if (mif.start && cyc > busy_until) begin
        case (mif.op_e)
          OP_MULT, OP_MULTU: begin
            busy_until = cyc + 5; pend_at = cyc + 5; pend = 1;
            {pend_we, pend_val} = ref_op(mif.op_e, mif.rs_e, mif.rt_e);
          end
          OP_DIV, OP_DIVU: begin
            busy_until = cyc + 10; pend_at = cyc + 10; pend = 1;
            {pend_we, pend_val} = ref_op(mif.op_e, mif.rs_e, mif.rt_e);
          end
          OP_MTHI: m_hi = mif.rs_e;
          OP_MTLO: m_lo = mif.rs_e;
          default: ;
        endcase
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : cmp
    bit mb;
    logic [31:0] exp_rd;
    if (model_ok) begin
      mb = (cyc <= busy_until);
      exp_rd = (mif.op_e == OP_MFHI) ? m_hi : (mif.op_e == OP_MFLO) ? m_lo : 32'd0;
      chk("busy", 32'(mif.busy), 32'(mb));
      chk("hi", mif.hi, m_hi);
      chk("lo", mif.lo, m_lo);
      chk("stall_req", 32'(mif.stall_req), 32'(mif.md_use_d & (mif.start | mb)));
      chk("rd_data", mif.rd_data, exp_rd);
    end
  end

  task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic mu);
    @(posedge clk);
    #1;
    mif.start = st; mif.op_e = op; mif.rs_e = a; mif.rt_e = b; mif.md_use_d = mu;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output int ns);
    drive(1'b1, op, a, b, 1'b1);
    nb = 0; ns = 0;
    @(negedge clk);
    if (mif.stall_req) ns++;
    drive(1'b0, OP_MFHI, $urandom, $urandom, 1'b1);
    repeat (13) begin
      @(negedge clk);
      if (mif.busy) nb++;
      if (mif.stall_req) ns++;
    end
  endtask

  int nb, ns;
  logic [2:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    mif.start = 0; mif.op_e = OP_MULT; mif.rs_e = 0; mif.rt_e = 0; mif.md_use_d = 0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(mif.busy), 32'd0);
    chk("reset_hi", mif.hi, 32'd0);
    chk("reset_lo", mif.lo, 32'd0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, nb, ns);
    chk("mult_busy_cycles", 32'(nb), 32'd5);
    chk("mult_hi", mif.hi, 32'hFFFF_FFFF);
    chk("mult_lo", mif.lo, 32'hFFFF_FFF1);
    chk("mfhi_rd", mif.rd_data, 32'hFFFF_FFFF);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, nb, ns);
    chk("multu_hi", mif.hi, 32'h0000_0001);
    chk("multu_lo", mif.lo, 32'hFFFF_FFFE);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb, ns);
    chk("div_busy_cycles", 32'(nb), 32'd10);
    chk("div_stall_cycles", 32'(ns), 32'd11);
    chk("div_lo", mif.lo, 32'hFFFF_FFFD);
    chk("div_hi", mif.hi, 32'hFFFF_FFFF);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, ns);
    chk("divovf_lo", mif.lo, 32'h8000_0000);
    chk("divovf_hi", mif.hi, 32'd0);

    run_op(OP_MTHI, 32'h11, 32'd0, nb, ns);
    chk("mthi_busy_cycles", 32'(nb), 32'd0);
    run_op(OP_MTLO, 32'h22, 32'd0, nb, ns);
    chk("mtlo_hi_kept", mif.hi, 32'h11);
    run_op(OP_DIVU, 32'd7, 32'd0, nb, ns);
    chk("divu0_busy_cycles", 32'(nb), 32'd10);
    chk("divu0_hi", mif.hi, 32'h11);
    chk("divu0_lo", mif.lo, 32'h22);

    drive(1'b1, OP_DIV, 32'd100, 32'd7, 1'b1);
    drive(1'b0, OP_MFLO, 32'd1, 32'd1, 1'b1);
    drive(1'b1, OP_MULT, 32'd3, 32'd3, 1'b1);
    drive(1'b1, OP_MTHI, 32'hDEAD, 32'd0, 1'b1);
    drive(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
    repeat (12) @(negedge clk);
    chk("busy_start_lo", mif.lo, 32'd14);
    chk("busy_start_hi", mif.hi, 32'd2);

    drive(1'b1, OP_MULT, 32'd7, 32'd9, 1'b0);
    drive(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
    drive(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(mif.busy), 32'd0);
    chk("midrst_hi", mif.hi, 32'd0);
    repeat (8) @(negedge clk);
    chk("midrst_lo_late", mif.lo, 32'd0);

    run_op(OP_MTLO, 32'h55, 32'd0, nb, ns);
    run_op(OP_MTHI, 32'hABCD, 32'd0, nb, ns);
    chk("mthi2_busy_cycles", 32'(nb), 32'd0);
    chk("mthi2_hi", mif.hi, 32'hABCD);
    chk("mthi2_lo", mif.lo, 32'h55);

    repeat (3000) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      drive(($urandom_range(0, 2) == 0), rop, ra, rb, 1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk); #1 reset = 1'b1; mif.start = 1'b0;
    repeat (14) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
